result_receiver: RTL
====================

Name: result_receiver

Overview:
- Receiving end of the serialized result stream that the systolic-array controller drives out of the PISO during its SEND phase.
- Captures one accumulator word per cycle while `send` is high and tags each word with its (row, col) position in the N x M result matrix.
- Buffers words in a small FIFO and presents them to the host over a valid/ready handshake.
- Flags overflow and protocol errors, and pulses `done` once a whole matrix has been delivered.

Parameters:
- N, 3, rows of result matrix (rows of matrix A)
- M, 3, columns of result matrix (columns of matrix B)
- DATA_W, 32, width of one serialized result word
- FIFO_DEPTH, 4, output buffer entries; power of 2, >= 2

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- send  in  1  upstream serializer is presenting a word this cycle; no backpressure
- ser_data  in  DATA_W  serialized result word, valid when send=1
- out_valid  out  1  FIFO head valid
- out_ready  in  1  host accepts head
- out_data  out  DATA_W  head word
- out_row  out  RW=max(1,$clog2(N))  row index of head word
- out_col  out  CW=max(1,$clog2(M))  column index of head word
- out_last  out  1  head word is element (N-1, M-1)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, matrix fully delivered
- overflow  out  1  sticky: a word arrived while FIFO full and no pop
- proto_err  out  1  sticky: send=1 while in DRAIN

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; FIFO empty; row/col counters=0.
  - out_valid=0; out_data, out_row, out_col, out_last=0.
  - busy=0, done=0, overflow=0, proto_err=0.
  - Reset mid-stream discards all buffered words and aborts the matrix; the next stream starts at (0,0).
- Capture: on each edge with send=1 in IDLE or RECV, push {ser_data, row, col, last} into the FIFO.
  - last=1 iff row=N-1 and col=M-1.
- Counters (element position):
  - col increments on every capture and wraps M-1 -> 0, incrementing row.
  - After element (N-1, M-1), both counters return to 0.
  - Counters advance even when the word is dropped for overflow, so indices stay aligned with the stream.
- State machine:
  - IDLE: send=1 -> capture element (0,0), go RECV. If N*M=1, go DRAIN instead.
  - RECV:
    - send=1 -> capture.
    - On capture of element N*M-1 -> DRAIN.
    - send=0 -> hold counters (a pause is legal, no error).
  - DRAIN:
    - send=1 -> word ignored, proto_err<=1, counters hold.
    - When the FIFO becomes empty through a pop of the last entry (or is already empty on entry) -> IDLE, with done=1 in the following cycle for exactly one cycle.
- FIFO:
  - Standard circular buffer with a count register (0..FIFO_DEPTH); head is registered.
  - Latency: a word captured at edge k is visible at out_* after edge k (same cycle k+1) if the FIFO was empty.
  - Pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle: both happen, count unchanged; when full this is not an overflow.
  - Push when full with no pop: word dropped, overflow<=1.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags clear only on reset.
- out_* hold their values while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: RESULT_RECEIVER_CHECKSUM_EN.
- Defined:
  - Adds output port `checksum` (DATA_W bits): XOR of every word captured in the current matrix, including dropped words.
  - Cleared on entry to RECV from IDLE, before the first word is folded in.
  - Stable from the `done` pulse until the next matrix starts; 0 after reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (N=3, M=3, DATA_W=32, FIFO_DEPTH=4):
1. Hold rst=0 for 2 cycles -> out_valid=0, busy=0, done=0, overflow=0, proto_err=0.
2. send=1 for 9 cycles with ser_data=1..9, out_ready=1:
   - out_data 1..9 in order with (row,col) = (0,0),(0,1),(0,2),(1,0)..(2,2).
   - out_last=1 only with 9; each word appears 1 cycle after capture.
   - done pulses once, busy=0 afterwards.
3. Same stream with out_ready=0:
   - overflow=1 after the 5th word.
   - Raise out_ready: outputs exactly 1,2,3,4 at (0,0),(0,1),(0,2),(1,0) with out_last=0.
   - done pulses after the 4th pop.
4. send=1 for words 1..4, send=0 for 3 cycles, send=1 for words 5..9 -> indices continuous (word 5 at (1,1)), no flags, done once.
5. Drive rst=0 after word 5 with out_ready=0 -> FIFO empty, out_valid=0. A new stream of 10..18 comes out as 10 at (0,0) ... 18 at (2,2).
6. With out_ready=0 after all 9 words, assert send=1 with ser_data=0xDEAD -> proto_err=1 and 0xDEAD never appears on out_data.

Source files
------------

// File: rtl/result_receiver.sv
// ============================================================================
// Module   : result_receiver
// Brief    : Captures the serialized systolic-array result stream, tags each
//            word with its (row, col) position and buffers it for a
//            valid/ready host port. Optional: RESULT_RECEIVER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module result_receiver #(
    parameter int N          = 3,
    parameter int M          = 3,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int RW        = (N > 1) ? $clog2(N) : 1,
    localparam int CW        = (M > 1) ? $clog2(M) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic [DATA_W-1:0] ser_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RW-1:0]     out_row,
    output logic [CW-1:0]     out_col,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              overflow,
`ifdef RESULT_RECEIVER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              proto_err
);

    localparam int EW   = DATA_W + RW + CW + 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    localparam logic [RW-1:0]   ROW_LAST = RW'(N - 1);
    localparam logic [CW-1:0]   COL_LAST = CW'(M - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [EW-1:0]   head_q, head_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            overflow_q, overflow_d;
    logic            proto_err_q, proto_err_d;

    logic            elem_last;
    logic            capture;
    logic            pop;
    logic            full;
    logic            push;
    logic [EW-1:0]   push_word;

`ifdef RESULT_RECEIVER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

    always_comb begin
        elem_last = (row_q == ROW_LAST) && (col_q == COL_LAST);
        capture   = send && (state_q != S_DRAIN);
        pop       = out_valid_q && out_ready;
        full      = (count_q == CNT_FULL);
        push      = capture && (!full || pop);
        push_word = {ser_data, row_q, col_q, elem_last};

        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        head_d      = head_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        proto_err_d = proto_err_q;
`ifdef RESULT_RECEIVER_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif

        // Position counters track the stream even when a word is dropped.
        if (capture) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = elem_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CNTW'(push) - CNTW'(pop);
        if (capture && full && !pop) overflow_d = 1'b1;

        // The slot being written this edge becomes the head when it is the
        // only entry left after the pop.
        out_valid_d = (count_d != '0);
        if (out_valid_d) begin
            head_d = (push && (rd_ptr_d == wr_ptr_q)) ? push_word : mem_q[rd_ptr_d];
        end

        case (state_q)
            S_IDLE: begin
                if (send) begin
                    state_d = elem_last ? S_DRAIN : S_RECV;
`ifdef RESULT_RECEIVER_CHECKSUM_EN
                    checksum_d = ser_data;
`endif
                end
            end
            S_RECV: begin
                if (send) begin
                    if (elem_last) state_d = S_DRAIN;
`ifdef RESULT_RECEIVER_CHECKSUM_EN
                    checksum_d = checksum_q ^ ser_data;
`endif
                end
            end
            S_DRAIN: begin
                if (send) proto_err_d = 1'b1;
                if (count_d == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
`ifdef RESULT_RECEIVER_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
`ifdef RESULT_RECEIVER_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_word;
    end

    assign out_valid = out_valid_q;
    assign out_data  = head_q[EW-1 -: DATA_W];
    assign out_row   = head_q[RW+CW : CW+1];
    assign out_col   = head_q[CW : 1];
    assign out_last  = head_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign proto_err = proto_err_q;
`ifdef RESULT_RECEIVER_CHECKSUM_EN
    assign checksum  = checksum_q;
`endif

endmodule

`default_nettype wire
